// File: rtl/seven_seg_pkg.sv
// Shared 7-segment constants and the BCD-to-segment encoder used by seven_seg_digit.
// Codes are common-anode (0 = lit), bit order {dp,g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam int SEG_DP_BIT = 7;

    localparam logic [7:0] SEG_TABLE [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Any non-decimal code renders as a dash, which is how out-of-range fields surface.
    function automatic logic [7:0] seg_encode(input logic [3:0] bcd, input logic dp_on);
        logic [7:0] code;
        if (bcd <= 4'd9) begin
            code = SEG_TABLE[bcd];
        end else begin
            code = SEG_DASH;
        end
        if (dp_on) begin
            code[SEG_DP_BIT] = 1'b0;
        end
        return code;
    endfunction

endpackage

// File: rtl/seven_seg_digit.sv
// One display digit: 4-bit BCD plus decimal-point request to an active-low segment code.
module seven_seg_digit
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp_on,
    output logic [7:0] code
);

    assign code = seg_encode(bcd, dp_on);

endmodule

// File: rtl/seven_seg_encoder.sv
// Stopwatch mm:ss.hh to six registered 7-segment codes, one clk of latency.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks a leading zero on the minutes tens digit.
module seven_seg_encoder
    import seven_seg_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] mins_in,
    input  logic [5:0] secs_in,
    input  logic [6:0] decs_in,
    output logic [7:0] mins_10,
    output logic [7:0] min_1,
    output logic [7:0] secs_10,
    output logic [7:0] sec_1,
    output logic [7:0] tenths,
    output logic [7:0] hundredths
);

    localparam logic [3:0] BCD_BAD = 4'hF;

    logic       mins_bad, secs_bad, decs_bad;
    logic [3:0] mins_t, mins_u, secs_t, secs_u, decs_t, decs_u;
    logic [7:0] mins_t_code, mins_u_code, secs_t_code, secs_u_code, decs_t_code, decs_u_code;
    logic [7:0] mins_t_sel;

    function automatic logic [7:0] polarity(input logic [7:0] c);
        return (ACTIVE_LOW != 0) ? c : ~c;
    endfunction

    assign mins_bad = (mins_in > 7'd99);
    assign secs_bad = (secs_in > 6'd59);
    assign decs_bad = (decs_in > 7'd99);

    // An out-of-range field forces both of its digits to a non-decimal code, i.e. dash.
    assign mins_t = mins_bad ? BCD_BAD : 4'(mins_in / 7'd10);
    assign mins_u = mins_bad ? BCD_BAD : 4'(mins_in % 7'd10);
    assign secs_t = secs_bad ? BCD_BAD : 4'(secs_in / 6'd10);
    assign secs_u = secs_bad ? BCD_BAD : 4'(secs_in % 6'd10);
    assign decs_t = decs_bad ? BCD_BAD : 4'(decs_in / 7'd10);
    assign decs_u = decs_bad ? BCD_BAD : 4'(decs_in % 7'd10);

    seven_seg_digit u_mins_t (.bcd(mins_t), .dp_on(1'b0), .code(mins_t_code));
    seven_seg_digit u_mins_u (.bcd(mins_u), .dp_on(1'b1), .code(mins_u_code));
    seven_seg_digit u_secs_t (.bcd(secs_t), .dp_on(1'b0), .code(secs_t_code));
    seven_seg_digit u_secs_u (.bcd(secs_u), .dp_on(1'b1), .code(secs_u_code));
    seven_seg_digit u_decs_t (.bcd(decs_t), .dp_on(1'b0), .code(decs_t_code));
    seven_seg_digit u_decs_u (.bcd(decs_u), .dp_on(1'b0), .code(decs_u_code));

`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign mins_t_sel = (mins_t == 4'd0) ? SEG_BLANK : mins_t_code;
`else
    assign mins_t_sel = mins_t_code;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mins_10    <= polarity(SEG_BLANK);
            min_1      <= polarity(SEG_BLANK);
            secs_10    <= polarity(SEG_BLANK);
            sec_1      <= polarity(SEG_BLANK);
            tenths     <= polarity(SEG_BLANK);
            hundredths <= polarity(SEG_BLANK);
        end else begin
            mins_10    <= polarity(mins_t_sel);
            min_1      <= polarity(mins_u_code);
            secs_10    <= polarity(secs_t_code);
            sec_1      <= polarity(secs_u_code);
            tenths     <= polarity(decs_t_code);
            hundredths <= polarity(decs_u_code);
        end
    end

endmodule

// File: tb/tb_seven_seg_encoder.sv
// Directed bench for seven_seg_encoder: expected codes queued at drive time, checked one clk later.
module tb_seven_seg_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] mins_in;
    logic [5:0] secs_in;
    logic [6:0] decs_in;
    logic [7:0] mins_10, min_1, secs_10, sec_1, tenths, hundredths;

    typedef struct packed {
        logic [7:0] m10;
        logic [7:0] m1;
        logic [7:0] s10;
        logic [7:0] s1;
        logic [7:0] t;
        logic [7:0] h;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   total = 0;
    int   bad   = 0;

    localparam logic [7:0] PAT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    seven_seg_encoder #(.ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst),
        .mins_in(mins_in), .secs_in(secs_in), .decs_in(decs_in),
        .mins_10(mins_10), .min_1(min_1), .secs_10(secs_10),
        .sec_1(sec_1), .tenths(tenths), .hundredths(hundredths)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc(int d, bit dp, bit dash);
        logic [7:0] c;
        if (dash) c = 8'hBF;
        else      c = PAT[d];
        if (dp) c[7] = 1'b0;
        return c;
    endfunction

    function automatic exp_t model(int m, int s, int d);
        exp_t e;
        bit mb, sbd, db;
        mb  = (m > 99);
        sbd = (s > 59);
        db  = (d > 99);
        e.m10 = enc(m / 10, 1'b0, mb);
        e.m1  = enc(m % 10, 1'b1, mb);
        e.s10 = enc(s / 10, 1'b0, sbd);
        e.s1  = enc(s % 10, 1'b1, sbd);
        e.t   = enc(d / 10, 1'b0, db);
        e.h   = enc(d % 10, 1'b0, db);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (!mb && (m / 10 == 0)) e.m10 = 8'hFF;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, queue the expectation, compare 1 time unit after the next rising edge.
    task automatic apply(input bit r, input int m, input int s, input int d, input bit lat);
        exp_t e;
        @(negedge clk);
        rst     = r;
        mins_in = 7'(m);
        secs_in = 6'(s);
        decs_in = 7'(d);
        if (r) sb.push_back('1);
        else   sb.push_back(model(m, s, d));
        if (lat) begin
            #1;
            check("latency_hold_mins_10", mins_10, last.m10);
            check("latency_hold_sec_1", sec_1, last.s1);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("mins_10", mins_10, e.m10);
        check("min_1", min_1, e.m1);
        check("secs_10", secs_10, e.s10);
        check("sec_1", sec_1, e.s1);
        check("tenths", tenths, e.t);
        check("hundredths", hundredths, e.h);
        last = e;
    endtask

    initial begin
        rst     = 1'b1;
        mins_in = '0;
        secs_in = '0;
        decs_in = '0;
        last    = '1;

        apply(1'b1, 0, 0, 0, 1'b0);
        apply(1'b1, 0, 0, 0, 1'b0);
        apply(1'b0, 0, 0, 0, 1'b0);

        apply(1'b0, 12, 34, 56, 1'b1);
        apply(1'b0, 99, 59, 99, 1'b1);

        for (int i = 0; i < 100; i++) begin
            apply(1'b0, i, i % 59, i, 1'b0);
        end

        apply(1'b0, 100, 60, 127, 1'b0);
        apply(1'b0, 127, 63, 100, 1'b0);
        apply(1'b0, 100, 45, 7, 1'b0);

        apply(1'b0, 5, 0, 0, 1'b0);
        apply(1'b1, 12, 34, 56, 1'b0);
        apply(1'b0, 45, 6, 78, 1'b0);

        for (int k = 0; k < 20; k++) begin
            apply(1'b0, int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 127)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
